ad7643_slave_emulator: RTL and testbench

//   Synthesizable model of the AD7643 ADC in serial slave mode: the converter end of the

---
 rtl/ad7643_slave_emulator_if.sv | 15 +
 rtl/ad7643_slave_emulator.sv | 144 ++++++++++++++
 tb/tb_ad7643_slave_emulator.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ad7643_slave_emulator_if.sv
// rtl/ad7643_slave_emulator_if.sv - AD7643 serial slave-mode pin bundle
// Master drives convert start, chip select and serial clock; the converter answers.
interface ad7643_if;
  logic cnvst;
  logic cs;
  logic sclk;
  logic sdout;
  logic busy;
  logic sync;

  modport master (output cnvst, output cs, output sclk,
                  input sdout, input busy, input sync);
  modport slave  (input cnvst, input cs, input sclk,
                  output sdout, output busy, output sync);
endinterface

// File: rtl/ad7643_slave_emulator.sv
// rtl/ad7643_slave_emulator.sv - AD7643 serial slave-mode converter emulator
// Produces fixed, ramp, LFSR or external 18-bit samples behind a CNVST/CS/SCLK interface.
module ad7643_slave_emulator #(
  parameter int DATA_W      = 18,
  parameter int CONV_CYCLES = 150,
  parameter int SYNC_STAGES = 2,
  parameter int RAMP_STEP   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ad7643_if.slave           ad,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] fixval_i,
  input  logic [DATA_W-1:0] extdata_i,
  input  logic              clr_ovr_i,
  output logic              overrun_o,
  output logic [15:0]       conv_cnt_o
);

  localparam int CNT_W = $clog2(CONV_CYCLES);
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_READY, S_SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cnvst_sq, cs_sq, sclk_sq;
  logic                   cnvst_prev_q, sclk_prev_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BIT_W-1:0]       bitcnt_q;
  logic [DATA_W-1:0]      shreg_q, ramp_q, lfsr_q, sample;
  logic [15:0]            conv_cnt_q;
  logic                   overrun_q;
  logic                   cnvst_fall, sclk_fall, cs_n;
  logic                   load_cnt, expire, shift_en, set_ovr;

  assign cnvst_fall = cnvst_prev_q & ~cnvst_sq[SYNC_STAGES-1];
  assign sclk_fall  = sclk_prev_q & ~sclk_sq[SYNC_STAGES-1];
  assign cs_n       = cs_sq[SYNC_STAGES-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnvst_sq     <= '0;
      cs_sq        <= '0;
      sclk_sq      <= '0;
      cnvst_prev_q <= 1'b0;
      sclk_prev_q  <= 1'b0;
    end else begin
      cnvst_sq     <= {cnvst_sq[SYNC_STAGES-2:0], ad.cnvst};
      cs_sq        <= {cs_sq[SYNC_STAGES-2:0], ad.cs};
      sclk_sq      <= {sclk_sq[SYNC_STAGES-2:0], ad.sclk};
      cnvst_prev_q <= cnvst_sq[SYNC_STAGES-1];
      sclk_prev_q  <= sclk_sq[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_cnt = 1'b0;
    expire   = 1'b0;
    shift_en = 1'b0;
    set_ovr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnvst_fall) begin
          state_d  = S_CONVERT;
          load_cnt = 1'b1;
        end
      end
      S_CONVERT: begin
        set_ovr = cnvst_fall;
        if (cnt_q == '0) begin
          expire  = 1'b1;
          state_d = S_READY;
        end
      end
      default: begin
        // A new convert start abandons whatever is left of the current word.
        if (cnvst_fall) begin
          set_ovr  = 1'b1;
          load_cnt = 1'b1;
          state_d  = S_CONVERT;
        end else if (sclk_fall && !cs_n) begin
          shift_en = 1'b1;
          state_d  = (bitcnt_q == BIT_W'(DATA_W-1)) ? S_IDLE : S_SHIFT;
        end
      end
    endcase
  end

  always_comb begin
    ad.busy  = (state_q == S_CONVERT);
    ad.sync  = (state_q == S_READY);
    ad.sdout = ((state_q == S_READY) || (state_q == S_SHIFT)) && !cs_n && shreg_q[DATA_W-1];
  end

  always_comb begin
    case (mode_i)
      2'd0:    sample = fixval_i;
      2'd1:    sample = ramp_q;
      2'd2:    sample = lfsr_q;
      default: sample = extdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      ramp_q     <= '0;
      lfsr_q     <= DATA_W'(1);
      conv_cnt_q <= '0;
    end else begin
      if (load_cnt) cnt_q <= CNT_W'(CONV_CYCLES-1);
      else if (state_q == S_CONVERT && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
      if (expire) begin
        shreg_q    <= sample;
        bitcnt_q   <= '0;
        ramp_q     <= ramp_q + DATA_W'(RAMP_STEP);
        // Fibonacci x^18 + x^11 + 1, shifting toward the MSB.
        lfsr_q     <= {lfsr_q[DATA_W-2:0], lfsr_q[DATA_W-1] ^ lfsr_q[10]};
        conv_cnt_q <= conv_cnt_q + 16'd1;
      end else if (shift_en) begin
        shreg_q  <= {shreg_q[DATA_W-2:0], 1'b0};
        bitcnt_q <= bitcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          overrun_q <= 1'b0;
    else if (set_ovr)   overrun_q <= 1'b1;
    else if (clr_ovr_i) overrun_q <= 1'b0;
  end

  assign overrun_o  = overrun_q;
  assign conv_cnt_o = conv_cnt_q;

endmodule

// File: tb/tb_ad7643_slave_emulator.sv
// tb/tb_ad7643_slave_emulator.sv - self-checking bench for the AD7643 slave emulator
// Drives the master side of the serial interface and compares words against a sample model.
module tb_ad7643_slave_emulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [17:0] fixval = '0;
  logic [17:0] extdata = '0;
  logic        clr_ovr = 1'b0;
  logic        overrun;
  logic [15:0] conv_cnt;

  int passed = 0;
  int total  = 0;

  ad7643_if bus ();

  ad7643_slave_emulator dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ad         (bus.slave),
    .mode_i     (mode),
    .fixval_i   (fixval),
    .extdata_i  (extdata),
    .clr_ovr_i  (clr_ovr),
    .overrun_o  (overrun),
    .conv_cnt_o (conv_cnt)
  );

  always #5 clk = ~clk;

  logic [17:0] m_ramp, m_lfsr;
  int          m_cnt;
  logic [17:0] exp_q[$];

  task automatic model_reset();
    m_ramp = '0;
    m_lfsr = 18'd1;
    m_cnt  = 0;
    exp_q.delete();
  endtask

  task automatic model_conv();
    logic [17:0] s;
    case (mode)
      2'd0: s = fixval;
      2'd1: s = m_ramp;
      2'd2: s = m_lfsr;
      default: s = extdata;
    endcase
    exp_q.push_back(s);
    m_ramp = 18'((int'(m_ramp) + 1) % (1 << 18));
    m_lfsr = {m_lfsr[16:0], m_lfsr[17] ^ m_lfsr[10]};
    m_cnt  = (m_cnt + 1) % 65536;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    model_reset();
    cyc(2);
  endtask

  // Starts a conversion, optionally pulsing CNVST or changing MODE while busy.
  task automatic do_conv(input int abort_at, input int mode_at, input logic [1:0] mode_new,
                         output int width, output int lat);
    lat = 0;
    bus.cnvst = 1'b0;
    while (!bus.busy && lat < 20) begin
      cyc(1);
      lat++;
    end
    bus.cnvst = 1'b1;
    width = 0;
    while (bus.busy && width < 1000) begin
      if (width == abort_at)     bus.cnvst = 1'b0;
      if (width == abort_at + 4) bus.cnvst = 1'b1;
      if (width == mode_at)      mode = mode_new;
      cyc(1);
      width++;
    end
    model_conv();
  endtask

  task automatic read_bits(input int n, output logic [17:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = {w[16:0], bus.sdout};
      bus.sclk = 1'b1;
      cyc(4);
      bus.sclk = 1'b0;
      cyc(4);
    end
  endtask

  task automatic read_word(output logic [17:0] w);
    bus.cs = 1'b0;
    cyc(4);
    read_bits(18, w);
    bus.cs = 1'b1;
    cyc(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(3);
    total++; if (bus.sdout !== 1'b0) $display("FAIL reset_sdout: got %b expected 0", bus.sdout); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.sync !== 1'b0) $display("FAIL reset_sync: got %b expected 0", bus.sync); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passed++;
    total++; if (conv_cnt !== 16'd0) $display("FAIL reset_conv_cnt: got %0d expected 0", conv_cnt); else passed++;
    rst = 1'b0;
    model_reset();
    bus.cs = 1'b0;
    cyc(4);
    for (int i = 0; i < 4; i++) begin
      bus.sclk = 1'b1; cyc(4);
      bus.sclk = 1'b0; cyc(4);
      total++; if (bus.sdout !== 1'b0 || bus.busy !== 1'b0 || bus.sync !== 1'b0)
        $display("FAIL idle_sclk: got sdout=%b busy=%b sync=%b expected 0 0 0", bus.sdout, bus.busy, bus.sync);
      else passed++;
    end
    bus.cs = 1'b1;
    cyc(4);
  endtask

  task automatic test_fixed();
    int w, l;
    logic [17:0] word;
    mode = 2'd0;
    fixval = 18'h2A5A5;
    do_conv(-1, -1, 2'd0, w, l);
    total++; if (l !== 3) $display("FAIL busy_latency: got %0d expected 3", l); else passed++;
    total++; if (w !== 150) $display("FAIL busy_width: got %0d expected 150", w); else passed++;
    total++; if (bus.sync !== 1'b1) $display("FAIL sync_after_conv: got %b expected 1", bus.sync); else passed++;
    total++; if (conv_cnt !== 16'(m_cnt)) $display("FAIL fixed_conv_cnt: got %0d expected %0d", conv_cnt, m_cnt); else passed++;
    read_word(word);
    total++; if (word !== exp_q[0]) $display("FAIL fixed_word: got %h expected %h", word, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
    total++; if (bus.sdout !== 1'b0 || bus.sync !== 1'b0)
      $display("FAIL fixed_after_read: got sdout=%b sync=%b expected 0 0", bus.sdout, bus.sync);
    else passed++;
  endtask

  task automatic test_ramp();
    int w, l;
    logic [17:0] word;
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      do_conv(-1, -1, 2'd1, w, l);
      total++; if (bus.sync !== 1'b1) $display("FAIL ramp_sync_hi: got %b expected 1", bus.sync); else passed++;
      bus.cs = 1'b0;
      cyc(4);
      read_bits(1, word);
      total++; if (bus.sync !== 1'b0) $display("FAIL ramp_sync_lo: got %b expected 0", bus.sync); else passed++;
      bus.cs = 1'b1;
      cyc(4);
      bus.cs = 1'b0;
      cyc(4);
      begin
        logic [17:0] rest;
        read_bits(17, rest);
        word = {word[0], rest[16:0]};
      end
      bus.cs = 1'b1;
      cyc(4);
      total++; if (word !== exp_q[0]) $display("FAIL ramp_word%0d: got %h expected %h", i, word, exp_q[0]); else passed++;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_lfsr();
    int w, l;
    logic [17:0] word;
    do_reset();
    mode = 2'd2;
    for (int i = 0; i < 2; i++) begin
      do_conv(-1, -1, 2'd2, w, l);
      read_word(word);
      total++; if (word !== exp_q[0]) $display("FAIL lfsr_word%0d: got %h expected %h", i, word, exp_q[0]); else passed++;
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_overrun();
    int w, l;
    logic [17:0] word;
    mode = 2'd0;
    fixval = 18'($urandom);
    do_conv(50, -1, 2'd0, w, l);
    total++; if (w !== 150) $display("FAIL ovr_busy_width: got %0d expected 150", w); else passed++;
    total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", overrun); else passed++;
    read_word(word);
    total++; if (word !== exp_q[0]) $display("FAIL ovr_word: got %h expected %h", word, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
    clr_ovr = 1'b1;
    cyc(1);
    clr_ovr = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun); else passed++;
  endtask

  task automatic test_cs_pause();
    int w, l;
    logic [17:0] a, b, word;
    mode = 2'd0;
    fixval = 18'($urandom);
    do_conv(-1, -1, 2'd0, w, l);
    bus.cs = 1'b0; cyc(4);
    read_bits(9, a);
    bus.cs = 1'b1; cyc(20);
    bus.cs = 1'b0; cyc(4);
    read_bits(9, b);
    bus.cs = 1'b1; cyc(4);
    word = {a[8:0], b[8:0]};
    total++; if (word !== exp_q[0]) $display("FAIL pause_word: got %h expected %h", word, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
    fixval = 18'($urandom);
    do_conv(-1, -1, 2'd0, w, l);
    bus.cs = 1'b0; cyc(4);
    read_bits(5, a);
    bus.cs = 1'b1; cyc(4);
    void'(exp_q.pop_front());
    fixval = 18'($urandom);
    do_conv(-1, -1, 2'd0, w, l);
    total++; if (overrun !== 1'b1) $display("FAIL abort_overrun: got %b expected 1", overrun); else passed++;
    total++; if (w !== 150) $display("FAIL abort_busy_width: got %0d expected 150", w); else passed++;
    read_word(word);
    total++; if (word !== exp_q[0]) $display("FAIL abort_word: got %h expected %h", word, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_rst_mid();
    int w, l;
    logic [17:0] word;
    mode = 2'd1;
    do_conv(-1, -1, 2'd1, w, l);
    bus.cs = 1'b0; cyc(4);
    read_bits(7, word);
    rst = 1'b1;
    #1;
    total++; if (bus.sdout !== 1'b0 || bus.busy !== 1'b0 || bus.sync !== 1'b0)
      $display("FAIL rst_pins: got sdout=%b busy=%b sync=%b expected 0 0 0", bus.sdout, bus.busy, bus.sync);
    else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b expected 0", overrun); else passed++;
    total++; if (conv_cnt !== 16'd0) $display("FAIL rst_conv_cnt: got %0d expected 0", conv_cnt); else passed++;
    cyc(2);
    rst = 1'b0;
    bus.cs = 1'b1;
    model_reset();
    cyc(4);
    do_conv(-1, -1, 2'd1, w, l);
    read_word(word);
    total++; if (word !== exp_q[0]) $display("FAIL rst_ramp_word: got %h expected %h", word, exp_q[0]); else passed++;
    void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    int w, l;
    logic [17:0] word;
    for (int i = 0; i < 8; i++) begin
      mode    = 2'($urandom_range(0, 3));
      fixval  = 18'($urandom);
      extdata = 18'($urandom);
      do_conv(-1, int'($urandom_range(10, 120)), 2'($urandom_range(0, 3)), w, l);
      extdata = 18'($urandom);
      total++; if (w !== 150) $display("FAIL rand_busy_width%0d: got %0d expected 150", i, w); else passed++;
      read_word(word);
      total++; if (word !== exp_q[0]) $display("FAIL rand_word%0d: got %h expected %h", i, word, exp_q[0]); else passed++;
      void'(exp_q.pop_front());
      total++; if (conv_cnt !== 16'(m_cnt)) $display("FAIL rand_conv_cnt%0d: got %0d expected %0d", i, conv_cnt, m_cnt); else passed++;
    end
  endtask

  initial begin
    bus.cnvst = 1'b1;
    bus.cs    = 1'b1;
    bus.sclk  = 1'b0;
    test_reset();
    test_fixed();
    test_ramp();
    test_lfsr();
    test_overrun();
    test_cs_pause();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
